// File: rtl/fx3_burst_controller_if.sv
// ---------------------------------------------------------------------------
// fx3_burst_controller_if
// Handshake and status bundle between the FX3 burst controller and its
// surroundings (sample FIFO, FX3 GPIF, host control).
//
// Signals:
//   runEnable     host level, 1 = capture running
//   dataAvailable FIFO read-side used-words above threshold
//   fifoEmpty     FIFO read-side empty
//   fifoFull      FIFO full
//   fx3Ready      FX3 DMA buffer has space (watermark)
//   collectData   FIFO write enable level
//   readData      FIFO read request
//   fx3Write      data-bus word valid strobe to FX3
//   burstDone     one-cycle pulse with the last write of a burst
//   busy          controller active (not IDLE / ERROR)
//   errorFlag     sticky error indicator
//   errorCode     01 = overflow, 10 = underflow, 00 = none
//   burstCount    (BURST_STATS_EN only) completed bursts, wrapping
//   pauseCycles   (BURST_STATS_EN only) BURST cycles with fx3Ready low,
//                 saturating
//
// Modports: master = controller side, slave = environment side.
// Optional macro: BURST_STATS_EN adds the statistics signals.
// ---------------------------------------------------------------------------
interface fx3_burst_controller_if;
    logic        runEnable;
    logic        dataAvailable;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        fx3Ready;
    logic        collectData;
    logic        readData;
    logic        fx3Write;
    logic        burstDone;
    logic        busy;
    logic        errorFlag;
    logic [1:0]  errorCode;
`ifdef BURST_STATS_EN
    logic [15:0] burstCount;
    logic [15:0] pauseCycles;

    modport master (
        input  runEnable, dataAvailable, fifoEmpty, fifoFull, fx3Ready,
        output collectData, readData, fx3Write, burstDone, busy,
               errorFlag, errorCode, burstCount, pauseCycles
    );
    modport slave (
        output runEnable, dataAvailable, fifoEmpty, fifoFull, fx3Ready,
        input  collectData, readData, fx3Write, burstDone, busy,
               errorFlag, errorCode, burstCount, pauseCycles
    );
`else
    modport master (
        input  runEnable, dataAvailable, fifoEmpty, fifoFull, fx3Ready,
        output collectData, readData, fx3Write, burstDone, busy,
               errorFlag, errorCode
    );
    modport slave (
        output runEnable, dataAvailable, fifoEmpty, fifoFull, fx3Ready,
        input  collectData, readData, fx3Write, burstDone, busy,
               errorFlag, errorCode
    );
`endif
endinterface

// File: rtl/fx3_burst_controller.sv
// ---------------------------------------------------------------------------
// fx3_burst_controller
// Sequences the ADC-to-FX3 sample path in the fx3Clk domain: enables sample
// collection into the dual-clock FIFO, waits for the FIFO threshold, reads
// fixed-length bursts while the FX3 has buffer space, and produces the FX3
// write strobe aligned with the FIFO/converter read pipeline. Overflow and
// underflow are latched and stop collection until the host drops runEnable.
//
// Ports:
//   fx3Clk   FX3 interface clock (single clock domain)
//   reset    asynchronous, active-high reset
//   ctrlBus  fx3_burst_controller_if.master (handshake, strobes, status)
//
// Parameters:
//   BURST_LEN     words per burst (power of two, <= FIFO threshold + 1)
//   READ_LATENCY  cycles from readData to valid data word (1..4)
//   CNT_W         word counter width, 2**CNT_W >= BURST_LEN
//
// Optional macro: BURST_STATS_EN adds burstCount / pauseCycles outputs.
// ---------------------------------------------------------------------------
module fx3_burst_controller #(
    parameter int BURST_LEN    = 8192,
    parameter int READ_LATENCY = 2,
    parameter int CNT_W        = 14
) (
    input  logic                  fx3Clk,
    input  logic                  reset,
    fx3_burst_controller_if.master ctrlBus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        BURST     = 3'd2,
        FLUSH     = 3'd3,
        ERROR     = 3'd4
    } ctrlState_t;

    ctrlState_t              stateReg;
    ctrlState_t              stateNext;
    logic [CNT_W-1:0]        wordCountReg;
    logic [READ_LATENCY-1:0] readPipeReg;
    logic [READ_LATENCY-1:0] lastPipeReg;
    logic                    errorFlagReg;
    logic [1:0]              errorCodeReg;

    logic collectDataInt;
    logic readDataInt;
    logic busyInt;
    logic burstDoneInt;
    logic overflow;
    logic underflow;
    logic lastWord;
    logic burstEntry;
    logic errorEntry;
    logic pipeFlush;

    // Error sources. Overflow is checked first in every decision that
    // distinguishes the two, so it wins when both are present.
    assign overflow  = ctrlBus.fifoFull &&
                       (stateReg == WAIT_DATA || stateReg == BURST || stateReg == FLUSH);
    assign underflow = readDataInt && ctrlBus.fifoEmpty;

    assign lastWord     = readDataInt && (wordCountReg == CNT_W'(BURST_LEN - 1));
    // The tap that marks the final word emerges together with its fx3Write.
    assign burstDoneInt = lastPipeReg[READ_LATENCY-1];
    assign burstEntry   = (stateReg == WAIT_DATA) && (stateNext == BURST);
    assign errorEntry   = (stateNext == ERROR) && (stateReg != ERROR);
    assign pipeFlush    = (stateNext == ERROR);

    // ---------------- state register ----------------
    always_ff @(posedge fx3Clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        stateNext = stateReg;
        if (overflow || underflow) begin
            stateNext = ERROR;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (ctrlBus.runEnable) stateNext = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (!ctrlBus.runEnable)
                        stateNext = IDLE;
                    else if (ctrlBus.dataAvailable && ctrlBus.fx3Ready)
                        stateNext = BURST;
                end
                BURST: begin
                    // runEnable is ignored here: a started burst always completes.
                    if (lastWord) stateNext = FLUSH;
                end
                FLUSH: begin
                    // Leaving on the final write gives exactly READ_LATENCY
                    // drain cycles after the last read.
                    if (burstDoneInt)
                        stateNext = ctrlBus.runEnable ? WAIT_DATA : IDLE;
                end
                ERROR: begin
                    if (!ctrlBus.runEnable) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        collectDataInt = 1'b0;
        readDataInt    = 1'b0;
        busyInt        = 1'b0;
        case (stateReg)
            WAIT_DATA: begin
                collectDataInt = 1'b1;
                busyInt        = 1'b1;
            end
            BURST: begin
                collectDataInt = 1'b1;
                busyInt        = 1'b1;
                // A low watermark only pauses; words already in flight are
                // covered by the FX3 buffer margin.
                readDataInt    = ctrlBus.fx3Ready;
            end
            FLUSH: begin
                collectDataInt = 1'b1;
                busyInt        = 1'b1;
            end
            default: begin
                collectDataInt = 1'b0;
                readDataInt    = 1'b0;
                busyInt        = 1'b0;
            end
        endcase
    end

    assign ctrlBus.collectData = collectDataInt;
    assign ctrlBus.readData    = readDataInt;
    assign ctrlBus.busy        = busyInt;
    assign ctrlBus.fx3Write    = readPipeReg[READ_LATENCY-1];
    assign ctrlBus.burstDone   = burstDoneInt;
    assign ctrlBus.errorFlag   = errorFlagReg;
    assign ctrlBus.errorCode   = errorCodeReg;

    // ---------------- burst word counter ----------------
    always_ff @(posedge fx3Clk or posedge reset) begin
        if (reset) begin
            wordCountReg <= '0;
        end else if (burstEntry) begin
            wordCountReg <= '0;
        end else if (readDataInt) begin
            wordCountReg <= wordCountReg + CNT_W'(1);
        end
    end

    // ---------------- read-to-write delay line ----------------
    // Mirrors the FIFO q register plus converter register so fx3Write lines
    // up with valid data. Cleared when entering ERROR so nothing further is
    // strobed into the FX3.
    always_ff @(posedge fx3Clk or posedge reset) begin
        if (reset) begin
            readPipeReg <= '0;
            lastPipeReg <= '0;
        end else if (pipeFlush) begin
            readPipeReg <= '0;
            lastPipeReg <= '0;
        end else begin
            readPipeReg[0] <= readDataInt;
            lastPipeReg[0] <= lastWord;
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                readPipeReg[i] <= readPipeReg[i-1];
                lastPipeReg[i] <= lastPipeReg[i-1];
            end
        end
    end

    // ---------------- sticky error status ----------------
    always_ff @(posedge fx3Clk or posedge reset) begin
        if (reset) begin
            errorFlagReg <= 1'b0;
            errorCodeReg <= 2'b00;
        end else if (errorEntry) begin
            errorFlagReg <= 1'b1;
            errorCodeReg <= overflow ? 2'b01 : 2'b10;
        end else if (stateReg == ERROR && stateNext == IDLE) begin
            errorFlagReg <= 1'b0;
            errorCodeReg <= 2'b00;
        end
    end

`ifdef BURST_STATS_EN
    // ---------------- burst statistics ----------------
    logic [15:0] burstCountReg;
    logic [15:0] pauseCyclesReg;
    logic        statsClear;

    assign statsClear = (stateReg == IDLE) && (stateNext == WAIT_DATA);

    always_ff @(posedge fx3Clk or posedge reset) begin
        if (reset) begin
            burstCountReg  <= 16'h0000;
            pauseCyclesReg <= 16'h0000;
        end else if (statsClear) begin
            burstCountReg  <= 16'h0000;
            pauseCyclesReg <= 16'h0000;
        end else begin
            if (burstDoneInt)
                burstCountReg <= burstCountReg + 16'h0001;
            if (stateReg == BURST && !ctrlBus.fx3Ready && pauseCyclesReg != 16'hFFFF)
                pauseCyclesReg <= pauseCyclesReg + 16'h0001;
        end
    end

    assign ctrlBus.burstCount  = burstCountReg;
    assign ctrlBus.pauseCycles = pauseCyclesReg;
`endif

endmodule

// File: tb/tb_fx3_burst_controller.sv
// ---------------------------------------------------------------------------
// tb_fx3_burst_controller
// Self-checking bench for fx3_burst_controller. A phase-level reference
// model (issued-word count, queue of pending writes keyed by due cycle)
// predicts every output each cycle; directed scenarios cover reset, runEnable
// drop mid-burst, watermark pause, overflow, underflow and their priority,
// followed by a randomized run. Define BURST_STATS_EN to also check the
// statistics outputs.
// ---------------------------------------------------------------------------
module tb_fx3_burst_controller;
    localparam int BL  = 256;
    localparam int LAT = 2;
    localparam int CW  = 8;

    logic fx3Clk = 1'b0;
    logic reset  = 1'b1;
    always #5 fx3Clk = ~fx3Clk;

    fx3_burst_controller_if ctrlBus();

    fx3_burst_controller #(
        .BURST_LEN   (BL),
        .READ_LATENCY(LAT),
        .CNT_W       (CW)
    ) dut (
        .fx3Clk (fx3Clk),
        .reset  (reset),
        .ctrlBus(ctrlBus)
    );

    int checkCount = 0;
    int errorCount = 0;
    int cycle      = 0;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_WAIT, M_BURST, M_DRAIN, M_FAULT} phase_t;
    typedef struct {
        int due;
        bit last;
    } pend_t;

    phase_t      mPhase;
    int          mIssued;
    logic [1:0]  mCode;
    pend_t       writeQ[$];
    logic [15:0] mBursts;
    logic [15:0] mPause;
    int          writesThisBurst;
    int          donePulses;

    function automatic logic [7:0] dutOuts();
        return {ctrlBus.collectData, ctrlBus.readData, ctrlBus.fx3Write, ctrlBus.burstDone,
                ctrlBus.busy, ctrlBus.errorFlag, ctrlBus.errorCode};
    endfunction

    task automatic modelClear();
        mPhase  = M_IDLE;
        mIssued = 0;
        mCode   = 2'b00;
        writeQ.delete();
        mBursts = 16'h0;
        mPause  = 16'h0;
        writesThisBurst = 0;
    endtask

    task automatic enterFault(input logic [1:0] code);
        mPhase = M_FAULT;
        mCode  = code;
        writeQ.delete();
        writesThisBurst = 0;
        $display("error entered code %0d at cycle %0d", code, cycle);
    endtask

    // One clock: drive inputs at the falling edge, compare outputs, then
    // advance the model with the inputs the DUT will see at the rising edge.
    task automatic stepCycle(input bit run, input bit avail, input bit full,
                             input bit empty, input bit ready);
        bit expCollect, expRd, expWr, expDone;
        @(negedge fx3Clk);
        ctrlBus.runEnable     = run;
        ctrlBus.dataAvailable = avail;
        ctrlBus.fifoFull      = full;
        ctrlBus.fifoEmpty     = empty;
        ctrlBus.fx3Ready      = ready;
        #1;
        expCollect = (mPhase == M_WAIT || mPhase == M_BURST || mPhase == M_DRAIN);
        expRd      = (mPhase == M_BURST) && ready;
        expWr      = (writeQ.size() > 0) && (writeQ[0].due == cycle);
        expDone    = expWr && writeQ[0].last;
        checkEq("outs{col,rd,wr,done,busy,ef,ec}", dutOuts(),
                {expCollect, expRd, expWr, expDone, expCollect, (mPhase == M_FAULT), mCode});
`ifdef BURST_STATS_EN
        checkEq("burstCount", ctrlBus.burstCount, mBursts);
        checkEq("pauseCycles", ctrlBus.pauseCycles, mPause);
`endif
        if (ctrlBus.fx3Write) writesThisBurst++;
        if (ctrlBus.burstDone) begin
            donePulses++;
            checkEq("burstWrites", writesThisBurst, BL);
            $display("burst done at cycle %0d with %0d writes", cycle, writesThisBurst);
            writesThisBurst = 0;
        end

        if (expWr) void'(writeQ.pop_front());
        if (mPhase == M_BURST && !ready && mPause != 16'hFFFF) mPause++;
        if (expDone) mBursts++;
        if (expCollect && full) begin
            enterFault(2'b01);
        end else if (expRd && empty) begin
            enterFault(2'b10);
        end else begin
            case (mPhase)
                M_IDLE: if (run) begin
                    mPhase  = M_WAIT;
                    mBursts = 16'h0;
                    mPause  = 16'h0;
                end
                M_WAIT: if (!run) mPhase = M_IDLE;
                        else if (avail && ready) begin
                            mPhase  = M_BURST;
                            mIssued = 0;
                        end
                M_BURST: if (expRd) begin
                    writeQ.push_back('{due: cycle + LAT, last: (mIssued == BL - 1)});
                    mIssued++;
                    if (mIssued == BL) mPhase = M_DRAIN;
                end
                M_DRAIN: if (expDone) mPhase = run ? M_WAIT : M_IDLE;
                M_FAULT: if (!run) begin
                    mPhase = M_IDLE;
                    mCode  = 2'b00;
                end
                default: ;
            endcase
        end
        cycle++;
    endtask

    // Reset asserted between clock edges; outputs must fall before the next edge.
    task automatic applyReset();
        @(negedge fx3Clk);
        #2;
        reset = 1'b1;
        #1;
        checkEq("asyncResetOuts", dutOuts(), 8'h00);
        @(negedge fx3Clk);
        ctrlBus.runEnable     = 1'b0;
        ctrlBus.dataAvailable = 1'b0;
        ctrlBus.fifoFull      = 1'b0;
        ctrlBus.fifoEmpty     = 1'b0;
        ctrlBus.fx3Ready      = 1'b0;
        reset = 1'b0;
        modelClear();
        $display("reset applied at cycle %0d", cycle);
    endtask

    task automatic runToWord(input int words);
        int k = 0;
        while (!(mPhase == M_BURST && mIssued >= words) && k < words + 50) begin
            stepCycle(1, 1, 0, 0, 1);
            k++;
        end
    endtask

    initial begin
        bit run, avail, ready, full, empty;
        int pauseLeft;

        ctrlBus.runEnable     = 1'b0;
        ctrlBus.dataAvailable = 1'b0;
        ctrlBus.fifoFull      = 1'b0;
        ctrlBus.fifoEmpty     = 1'b0;
        ctrlBus.fx3Ready      = 1'b0;
        modelClear();
        donePulses = 0;
        #1;
        checkEq("resetState", dutOuts(), 8'h00);
        @(negedge fx3Clk);
        reset = 1'b0;

        // runEnable dropped at word 10: burst still completes, then IDLE.
        for (int k = 0; k < 12; k++) stepCycle(1, 1, 0, 0, 1);
        for (int k = 0; k < BL + LAT + 6; k++) stepCycle(0, 1, 0, 0, 1);
        checkEq("dropDones", donePulses, 1);
        checkEq("dropBusy", ctrlBus.busy, 1'b0);
        checkEq("dropCollect", ctrlBus.collectData, 1'b0);

        // Everything held high: two back-to-back bursts.
        donePulses = 0;
        for (int k = 0; k < 2 * BL + 2 * LAT + 8; k++) stepCycle(1, 1, 0, 0, 1);
        checkEq("holdDones", donePulses, 2);

        // Reset mid-burst; no writes may follow.
        applyReset();
        for (int k = 0; k < 6; k++) stepCycle(0, 0, 0, 0, 1);

        // Watermark pause of 100 cycles at word 100.
        donePulses = 0;
        runToWord(100);
        for (int k = 0; k < 100; k++) stepCycle(1, 1, 0, 0, 0);
        for (int k = 0; k < BL + 20 && donePulses == 0; k++) stepCycle(1, 1, 0, 0, 1);
        checkEq("pauseDone", donePulses, 1);
`ifdef BURST_STATS_EN
        checkEq("pauseTotal", ctrlBus.pauseCycles, 100);
        checkEq("pauseBursts", ctrlBus.burstCount, 1);
`endif
        for (int k = 0; k < 3; k++) stepCycle(0, 0, 0, 0, 1);

        // Overflow while waiting for data.
        for (int k = 0; k < 3; k++) stepCycle(1, 0, 0, 0, 1);
        stepCycle(1, 0, 1, 0, 1);
        stepCycle(1, 0, 0, 0, 1);
        checkEq("ovfCode", ctrlBus.errorCode, 2'b01);
        checkEq("ovfFlag", ctrlBus.errorFlag, 1'b1);
        checkEq("ovfCollect", ctrlBus.collectData, 1'b0);
        stepCycle(0, 0, 0, 0, 1);
        stepCycle(0, 0, 0, 0, 1);
        checkEq("ovfClearFlag", ctrlBus.errorFlag, 1'b0);
        checkEq("ovfClearCode", ctrlBus.errorCode, 2'b00);

        // Underflow during an active read.
        runToWord(5);
        stepCycle(1, 1, 0, 1, 1);
        stepCycle(1, 1, 0, 0, 1);
        checkEq("udfCode", ctrlBus.errorCode, 2'b10);
        checkEq("udfWrite", ctrlBus.fx3Write, 1'b0);
        stepCycle(0, 0, 0, 0, 1);
        stepCycle(0, 0, 0, 0, 1);
        checkEq("udfClearFlag", ctrlBus.errorFlag, 1'b0);

        // Full and empty together: overflow wins.
        runToWord(7);
        stepCycle(1, 1, 1, 1, 1);
        stepCycle(1, 1, 0, 0, 1);
        checkEq("bothCode", ctrlBus.errorCode, 2'b01);
        stepCycle(0, 0, 0, 0, 1);
        stepCycle(0, 0, 0, 0, 1);

        // Randomized run; errors injected in the second half.
        run = 1'b1;
        pauseLeft = 0;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 199) == 0) run = !run;
            avail = ($urandom_range(0, 3) != 0);
            if (pauseLeft > 0) begin
                ready = 1'b0;
                pauseLeft--;
            end else begin
                ready = 1'b1;
                if ($urandom_range(0, 39) == 0) pauseLeft = $urandom_range(1, 20);
            end
            full  = (n >= 2500) && ($urandom_range(0, 499) == 0);
            empty = (n >= 2500) && ($urandom_range(0, 299) == 0);
            stepCycle(run, avail, full, empty, ready);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
